data_memory_banked: RTL and testbench
=====================================

// Module: data_memory_banked
// PURPOSE
//  Parametrised single-port data memory for the MiniMIPS MEM stage; successor to the fixed 32x32 array.
//  Byte-addressed requests with valid/ready handshake, byte-enable writes, 1-cycle registered reads.
//  Zero-fill sweep after reset; misaligned/out-of-range error reporting. Sits between ALU address and WB mux.
// PARAMETERS
//  DATA_WIDTH  32   word width in bits; multiple of 8, >= 16
//  DEPTH       256  number of words; power of two, >= 4
//  ADDR_WIDTH  32   byte-address width; must cover DEPTH*DATA_WIDTH/8 bytes
// PORTS
//  clock           in   1             rising-edge clock
//  reset_n         in   1             asynchronous, active-low reset
//  req_valid       in   1             request present
//  req_ready       out  1             block can accept request
//  req_write       in   1             1 = write, 0 = read
//  address         in   ADDR_WIDTH    byte address
//  write_data      in   DATA_WIDTH    write word
//  byte_en         in   DATA_WIDTH/8  per-byte write enable (bit i -> bits 8i+7:8i)
//  read_valid      out  1             read_data valid this cycle
//  read_data       out  DATA_WIDTH    read word
//  addr_err        out  1             misaligned or out-of-range request (pulse)
//  parity_err      out  1             parity mismatch on read (pulse)
//  init_done       out  1             zero-fill sweep complete
// BEHAVIOUR
//  Reset (async, any cycle incl. mid-sweep): state=INIT, sweep counter=0; req_ready=0, read_valid=0,
//   read_data=0, addr_err=0, parity_err=0, init_done=0.
//  INIT: writes zero to word[cnt] each cycle, cnt++; after word DEPTH-1 -> IDLE; takes exactly DEPTH cycles.
//  IDLE: req_ready=1, init_done=1. Accept = req_valid & req_ready at rising edge.
//  word index = address[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; misaligned = address low bits != 0;
//   out-of-range = word index >= DEPTH.
//  Valid write: bytes with byte_en=1 updated at the accepting edge; others unchanged; no response.
//  Valid read: next cycle read_valid=1, read_data=word; one result per accepted read, back-to-back allowed.
//  Read of a word written in the previous cycle returns the new data (no bypass needed: write precedes read).
//  Error request: memory untouched; next cycle addr_err=1 for one cycle; if read, also read_valid=1,
//   read_data=0.
//  read_data holds last value when read_valid=0. Pulse outputs are 1 cycle wide.
//  byte_en ignored for reads; byte_en=0 write is legal no-op.
// CONFIGURATION
//  DMEM_PARITY_EN defined: each byte stores an extra even-parity bit, generated on write and in sweep;
//   on read, any byte mismatch sets parity_err=1 alongside read_valid (data still returned).
//  DMEM_PARITY_EN undefined: no parity storage; parity_err tied 0. Port list identical in both builds.
// STRUCTURE
//  Package dmem_pkg: state enum {INIT, IDLE}, localparams BYTES=DATA_WIDTH/8, OFFS_W=$clog2(BYTES),
//   IDX_W=$clog2(DEPTH), parity helper function.
//  Sub-module dmem_array: storage with byte-enable write port and registered read port (with optional
//   parity bits); top holds FSM, sweep counter, decode, error logic.
// TESTING
//  Reset, hold req_valid=0 -> req_ready=0 for 256 cycles, init_done=1 on cycle 257; read addr 0x40 -> 0.
//  Write 0xDEADBEEF @0x10 be=4'hF, then write 0x000000AA @0x10 be=4'b0001; read 0x10 -> 0xDEADBEAA.
//  Back-to-back reads 0x0,0x4,0x8 after writes 1,2,3 -> read_valid 3 consecutive cycles, data 1,2,3.
//  Read 0x12 (misaligned) and 0x400 (out of range) -> addr_err pulse, read_valid=1, read_data=0; memory unchanged.
//  Assert reset_n=0 mid-sweep at cnt=100 -> outputs to reset values; sweep restarts, takes 256 cycles again.
//  With DMEM_PARITY_EN: force flip bit 3 of word 5, read 0x14 -> parity_err=1 with read_valid; without: 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, default geometry and parity helper for the banked data memory
//
// Purpose : sweep/operate state encoding, default geometry of the data memory,
//           and the per-byte even-parity helper used when DMEM_PARITY_EN is defined.
// Ports   : none (package)

package dmem_pkg;

  typedef enum logic {
    INIT = 1'b0,   // zero-fill sweep in progress
    IDLE = 1'b1    // accepting requests
  } dmem_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int BYTES          = DEF_DATA_WIDTH / 8;
  localparam int OFFS_W         = $clog2(BYTES);
  localparam int IDX_W          = $clog2(DEF_DEPTH);

  // Even parity: the stored bit makes the 9-bit group have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with byte-enable write port and registered read port
//
// Purpose : DEPTH x DATA_WIDTH storage. One write port (byte enables) and one
//           registered read port. With DMEM_PARITY_EN defined, one even-parity bit
//           per byte is stored alongside the data and checked on every read.
// Ports   : clk_i, rst_ni     clock, async active-low reset (read register only)
//           we_i, widx_i, wdata_i, wbe_i   write strobe, word index, data, byte enables
//           re_i, ridx_i      read strobe and word index (result next cycle)
//           rclr_i            load zero into the read register (error reads)
//           rdata_o           registered read word, holds when no read/clear
//           perr_o            one-cycle parity mismatch flag aligned with rdata_o
// Macro   : DMEM_PARITY_EN

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH)-1:0]       widx_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wbe_i,
  input  logic                           re_i,
  input  logic                           rclr_i,
  input  logic [$clog2(DEPTH)-1:0]       ridx_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           perr_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is not reset; the zero-fill sweep initialises it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe_i[b]) begin
          mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[ridx_i];
    end else if (rclr_i) begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic          perr_q;

  function automatic logic [NB-1:0] gen_par(input logic [DATA_WIDTH-1:0] w);
    logic [NB-1:0] p;
    p = '0;
    for (int b = 0; b < NB; b++) begin
      p[b] = byte_parity(w[8*b +: 8]);
    end
    return p;
  endfunction

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe_i[b]) begin
          par_q[widx_i][b] <= byte_parity(wdata_i[8*b +: 8]);
        end
      end
    end
  end

  // Flag is a pulse: it only lives in the cycle after an actual array read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= re_i && (par_q[ridx_i] != gen_par(mem_q[ridx_i]));
    end
  end

  assign perr_o = perr_q;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/data_memory_banked.sv
// rtl/data_memory_banked.sv - MEM-stage data memory with handshake, byte enables and zero-fill sweep
//
// Purpose : single-port byte-addressed data memory. After reset it zero-fills every
//           word (DEPTH cycles), then accepts one request per cycle. Reads return
//           one cycle after acceptance; misaligned/out-of-range requests leave the
//           memory untouched and pulse addr_err (error reads return zero data).
// Ports   : clock, reset_n            clock, async active-low reset
//           req_valid / req_ready      request handshake
//           req_write, address         direction and byte address
//           write_data, byte_en        write word and per-byte enables
//           read_valid, read_data      read result (data holds when not valid)
//           addr_err, parity_err       one-cycle error pulses
//           init_done                  zero-fill sweep complete
// Macro   : DMEM_PARITY_EN enables per-byte parity storage and checking.

module data_memory_banked
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    read_valid,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    addr_err,
  output logic                    parity_err,
  output logic                    init_done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  dmem_state_e          state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic                 rvalid_q, rvalid_d;
  logic                 aerr_q, aerr_d;

  logic [IW-1:0]         req_idx;
  logic [ADDR_WIDTH-1:0] upper_bits;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;

  logic                  arr_we;
  logic [IW-1:0]         arr_widx;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [NB-1:0]         arr_wbe;
  logic                  arr_re;
  logic                  arr_rclr;

  // Any address bit above the word index means word index >= DEPTH.
  assign upper_bits   = address >> (OW + IW);
  assign out_of_range = |upper_bits;
  assign misaligned   = |address[OW-1:0];
  assign req_err      = misaligned | out_of_range;
  assign req_idx      = address[OW+IW-1:OW];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      aerr_q   <= aerr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rvalid_d  = 1'b0;
    aerr_d    = 1'b0;
    req_ready = 1'b0;
    init_done = 1'b0;
    arr_we    = 1'b0;
    arr_widx  = req_idx;
    arr_wdata = write_data;
    arr_wbe   = byte_en;
    arr_re    = 1'b0;
    arr_rclr  = 1'b0;

    unique case (state_q)
      INIT: begin
        arr_we    = 1'b1;
        arr_widx  = cnt_q;
        arr_wdata = '0;
        arr_wbe   = '1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        req_ready = 1'b1;
        init_done = 1'b1;
        // req_ready is 1 here, so req_valid alone means the request is accepted.
        if (req_valid) begin
          if (req_err) begin
            aerr_d = 1'b1;
            if (!req_write) begin
              rvalid_d = 1'b1;
              arr_rclr = 1'b1;
            end
          end else if (req_write) begin
            arr_we = 1'b1;
          end else begin
            arr_re   = 1'b1;
            rvalid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .we_i    (arr_we),
    .widx_i  (arr_widx),
    .wdata_i (arr_wdata),
    .wbe_i   (arr_wbe),
    .re_i    (arr_re),
    .rclr_i  (arr_rclr),
    .ridx_i  (req_idx),
    .rdata_o (read_data),
    .perr_o  (parity_err)
  );

  assign read_valid = rvalid_q;
  assign addr_err   = aerr_q;

endmodule

// File: tb/tb_data_memory_banked.sv
// tb/tb_data_memory_banked.sv - table-driven self-checking bench for data_memory_banked

module tb_data_memory_banked;

  localparam int SWEEP = 1 << dmem_pkg::IDX_W;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  byte_en;
  logic        read_valid;
  logic [31:0] read_data;
  logic        addr_err;
  logic        parity_err;
  logic        init_done;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory_banked dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .address    (address),
    .write_data (write_data),
    .byte_en    (byte_en),
    .read_valid (read_valid),
    .read_data  (read_data),
    .addr_err   (addr_err),
    .parity_err (parity_err),
    .init_done  (init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_ae;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},  {31'b0, req_ready},  32'd0);
    check({tag, " init_done"},  {31'b0, init_done},  32'd0);
    check({tag, " read_valid"}, {31'b0, read_valid}, 32'd0);
    check({tag, " read_data"},  read_data,           32'd0);
    check({tag, " addr_err"},   {31'b0, addr_err},   32'd0);
    check({tag, " parity_err"}, {31'b0, parity_err}, 32'd0);
  endtask

  // Starts right after reset release: ready must stay low for SWEEP cycles.
  task automatic run_sweep(input string tag);
    int early;
    early = 0;
    for (int i = 0; i < SWEEP; i++) begin
      if (req_ready !== 1'b0 || init_done !== 1'b0) early++;
      tick();
    end
    check({tag, " cycles ready during sweep"}, early, 32'd0);
    check({tag, " req_ready after sweep"}, {31'b0, req_ready}, 32'd1);
    check({tag, " init_done after sweep"}, {31'b0, init_done}, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a);
    req_valid = 1'b1;
    req_write = 1'b0;
    address   = a;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w5;
    logic        exp_pe;

    vecs[0]  = '{1'b0, 32'h40,  32'h0,        4'h0, 1'b1, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 1'b1, 32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h0,   32'h1,        4'hF, 1'b0, 32'hDEADBEAA, 1'b0};
    vecs[5]  = '{1'b1, 32'h4,   32'h2,        4'hF, 1'b0, 32'hDEADBEAA, 1'b0};
    vecs[6]  = '{1'b1, 32'h8,   32'h3,        4'hF, 1'b0, 32'hDEADBEAA, 1'b0};
    vecs[7]  = '{1'b1, 32'h1C,  32'h11223344, 4'h0, 1'b0, 32'hDEADBEAA, 1'b0};
    vecs[8]  = '{1'b0, 32'h1C,  32'h0,        4'h0, 1'b1, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h12,  32'h0,        4'hF, 1'b1, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 32'h11,  32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'h10,  32'h0,        4'h0, 1'b1, 32'hDEADBEAA, 1'b0};
    vecs[13] = '{1'b0, 32'h400, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
    vecs[14] = '{1'b1, 32'h20,  32'h12345678, 4'hA, 1'b0, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h20,  32'h0,        4'h0, 1'b1, 32'h12005600, 1'b0};
    vecs[16] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 32'h1,   32'h0,        4'h0, 1'b1, 32'h0,        1'b1};

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    address    = '0;
    write_data = '0;
    byte_en    = '0;

    tick();
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    run_sweep("first sweep");

    for (int i = 0; i < 18; i++) begin
      req_valid  = 1'b1;
      req_write  = vecs[i].wr;
      address    = vecs[i].addr;
      write_data = vecs[i].wdata;
      byte_en    = vecs[i].be;
      tick();
      req_valid = 1'b0;
      check($sformatf("vec%0d read_valid", i), {31'b0, read_valid}, {31'b0, vecs[i].exp_rv});
      check($sformatf("vec%0d read_data", i),  read_data,           vecs[i].exp_rd);
      check($sformatf("vec%0d addr_err", i),   {31'b0, addr_err},   {31'b0, vecs[i].exp_ae});
      check($sformatf("vec%0d parity_err", i), {31'b0, parity_err}, 32'd0);
    end

    exp_w5 = 32'h0;
    exp_pe = 1'b0;
`ifdef DMEM_PARITY_EN
    dut.u_array.mem_q[5][3] = 1'b1;
    exp_w5 = 32'h8;
    exp_pe = 1'b1;
`endif
    do_read(32'h14);
    check("parity read_valid", {31'b0, read_valid}, 32'd1);
    check("parity read_data",  read_data, exp_w5);
    check("parity parity_err", {31'b0, parity_err}, {31'b0, exp_pe});
    tick();
    check("parity pulse width", {31'b0, parity_err}, 32'd0);

    // Back-to-back reads of the three words written by the table.
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      address   = 32'(4 * i);
      tick();
      check($sformatf("b2b%0d read_valid", i), {31'b0, read_valid}, 32'd1);
      check($sformatf("b2b%0d read_data", i),  read_data, 32'(i + 1));
    end
    req_valid = 1'b0;
    tick();
    check("b2b idle read_valid", {31'b0, read_valid}, 32'd0);
    check("b2b idle read_data hold", read_data, 32'd3);
    check("b2b idle addr_err", {31'b0, addr_err}, 32'd0);

    // Async reset from IDLE clears the held read data at once.
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("idle reset");
    tick();
    reset_n = 1'b1;

    // Interrupt the sweep at counter value 100 and confirm a full restart.
    for (int i = 0; i < 100; i++) tick();
    check("mid sweep still busy", {31'b0, req_ready}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid-sweep reset");
    tick();
    reset_n = 1'b1;
    run_sweep("restarted sweep");

    do_read(32'h10);
    check("post-sweep read_valid", {31'b0, read_valid}, 32'd1);
    check("post-sweep word4 zeroed", read_data, 32'd0);
    do_read(32'h0);
    check("post-sweep word0 zeroed", read_data, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
